lsu_apb_master: RTL and testbench
=================================

# lsu_apb_master

APB initiator that carries pipeline load/store requests to the data memory and other APB responders on the data bus. It accepts one request at a time from the memory stage and drives the APB SETUP/ACCESS sequence. Byte strobes and lane-aligned write data are generated from the address offset. Read data is extracted and sign- or zero-extended, and a one-cycle response is returned with an error flag for misalignment, illegal size, PSLVERR or timeout.

## Interface
- TIMEOUT_CYC, 16: maximum ACCESS cycles spent waiting for pready_i; 0 disables the timeout.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  response is an error.
- psel_o, penable_o, pwrite_o  out  1 each  APB control.
- paddr_o  out  32  APB address, equal to req_addr_i.
- pwdata_o  out  32  lane-aligned write data.
- pstrb_o  out  4  byte strobes.
- prdata_i  in  32  APB read data.
- pready_i  in  1  responder ready.
- pslverr_i  in  1  responder error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **Request acceptance**
  - req_ready_o = (state == IDLE) & ~rst_i.
  - A request is accepted when req_valid_i & req_ready_o.
  - On acceptance, address, we, funct3 and wdata are registered.
- **Request check (at acceptance)**
  - Illegal size: store with funct3 not in {000, 001, 010}, or load with funct3 not in {000, 001, 010, 100, 101}.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - Either condition sends IDLE -> RESP with err = 1. No APB activity occurs.
  - Otherwise IDLE -> SETUP.
- **SETUP** (one cycle)
  - psel_o = 1, penable_o = 0; paddr_o, pwrite_o, pwdata_o and pstrb_o are valid.
  - Unconditionally -> ACCESS.
- **ACCESS**
  - psel_o = 1, penable_o = 1; all other APB outputs are held stable.
  - pready_i = 1 at the clock edge: capture prdata_i and pslverr_i, clear the wait counter, -> RESP.
  - Otherwise the wait counter increments.
  - If TIMEOUT_CYC ≠ 0 and the counter reaches TIMEOUT_CYC: -> RESP with err = 1.
- **RESP** (one cycle)
  - rsp_valid_o = 1, then -> IDLE.
- **Strobe and write-data rules** (off = addr[1:0])
  - Store byte: pstrb = 0001 << off.
  - Store halfword: pstrb = 0011 << off.
  - Store word: pstrb = 1111.
  - Loads: pstrb = 0000, pwdata = 0.
  - Stores: pwdata = req_wdata << (8 * off).
- **Load extraction**
  - s = prdata >> (8 * off).
  - B: sign-extend s[7:0]. BU: zero-extend s[7:0].
  - H: sign-extend s[15:0]. HU: zero-extend s[15:0].
  - W: prdata unchanged.
- **Errors**
  - rsp_err_o = misaligned | illegal | pslverr | timeout.
  - When rsp_err_o = 1, rsp_rdata_o = 0.
- **Outputs outside SETUP/ACCESS**: psel_o = penable_o = 0; paddr_o, pwdata_o and pstrb_o are 0.

## Timing
- **Reset**: all outputs 0, state IDLE, counter 0.
- **Reset during SETUP or ACCESS**:
  - psel_o and penable_o drop immediately (asynchronously).
  - No response is produced, and the in-flight request is discarded.
- **Latency**: accept at edge 0.
  - SETUP in cycle 1, ACCESS in cycle 2.
  - With pready in cycle 2, rsp_valid_o is high in cycle 3.
  - Each wait state adds one cycle.
  - Error at acceptance: rsp_valid_o is high in cycle 1.
- **Throughput**: req_ready_o returns high in the cycle after RESP.
  - Back-to-back requests issue once every 4 cycles at zero wait states.
- **Timeout at TIMEOUT_CYC = N**: ACCESS lasts exactly N cycles, then rsp_valid_o with err = 1.
  - pready_i arriving in the same cycle as the N-th count takes priority and gives a normal completion.
- **Ignored inputs**: pslverr_i and prdata_i are ignored unless pready_i = 1 in ACCESS.

## Test plan
- LW from 0x100 with prdata = 0xDEADBEEF and zero wait -> SETUP in cycle 1, ACCESS in cycle 2, rsp in cycle 3 with rdata 0xDEADBEEF and err 0.
- SB to 0x103 with wdata 0x000000A5 -> pstrb 1000, pwdata 0xA5000000, pwrite 1; rsp rdata 0.
- LB at 0x102 and LBU at 0x102, prdata = 0x00800000 -> rdata 0xFFFFFF80 and 0x00000080 respectively.
- LH at 0x101 -> rsp in cycle 1 with err 1; psel_o never asserts. Also funct3 = 011 on a load -> same result.
- pready held low with TIMEOUT_CYC = 16 -> penable high for 16 cycles, then rsp with err 1. Separately, pready after 3 waits with pslverr = 1 -> err 1, rdata 0.
- rst_i pulsed during ACCESS -> psel_o and penable_o low immediately, no rsp_valid_o; a request after reset completes normally.

Source files
------------

// File: rtl/lsu_apb_master.sv
// APB initiator for pipeline load/store requests: one request in flight, lane-aligned
// strobes and write data on the way out, extended read data and an error flag on the way back.
module lsu_apb_master #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [3:0]         strb_q, strb_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               legal;
  logic               misaligned;
  logic [1:0]         off;
  logic [3:0]         strb_new;
  logic [31:0]        shifted;
  logic [31:0]        load_data;
  logic               apb_active;

  assign req_ready_o = (state_q == IDLE) & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  assign off         = req_addr_i[1:0];

  // Request legality, alignment and lane placement, evaluated on the incoming request
  always_comb begin
    legal = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we_i;
      default:                legal = 1'b0;
    endcase
    misaligned = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                 ((req_funct3_i[1:0] == 2'b10) & (|req_addr_i[1:0]));
    strb_new = 4'b0000;
    if (req_we_i) begin
      case (req_funct3_i[1:0])
        2'b00:   strb_new = 4'b0001 << off;
        2'b01:   strb_new = 4'b0011 << off;
        default: strb_new = 4'b1111;
      endcase
    end
  end

  // Read data extraction from the addressed lane
  always_comb begin
    shifted = prdata_i >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h000000, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0000, shifted[15:0]};
      default: load_data = prdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          strb_d  = strb_new;
          wdata_d = req_we_i ? (req_wdata_i << {off, 3'b000}) : 32'h0;
          rdata_d = 32'h0;
          if (!legal || misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready wins over a timeout landing on the same edge
        if (pready_i) begin
          err_d   = pslverr_i;
          rdata_d = (pslverr_i || we_q) ? 32'h0 : load_data;
          cnt_d   = '0;
          state_d = RESP;
        end else if ((TIMEOUT_CYC != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYC)) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      strb_q  <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the state register so reset drops them at once
  assign apb_active  = (state_q == SETUP) | (state_q == ACCESS);
  assign psel_o      = apb_active;
  assign penable_o   = (state_q == ACCESS);
  assign pwrite_o    = apb_active & we_q;
  assign paddr_o     = apb_active ? addr_q  : 32'h0;
  assign pwdata_o    = apb_active ? wdata_q : 32'h0;
  assign pstrb_o     = apb_active ? strb_q  : 4'b0000;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = (state_q == RESP) ? rdata_q : 32'h0;
  assign rsp_err_o   = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_lsu_apb_master.sv
// Scoreboarded random/directed bench for lsu_apb_master with a wait-state APB responder.
module tb_lsu_apb_master;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  always #5 clk = ~clk;

  lsu_apb_master #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  typedef struct { logic [31:0] rdata; logic err; int unsigned cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic wr; logic [3:0] strb; logic [31:0] wdata; } apb_t;
  typedef struct { int unsigned waits; logic [31:0] prdata; logic slverr; } slv_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  slv_t slv_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Reference model: expected response and bus transfer from the request rules
  task automatic issue(input logic [31:0] addr, input logic we, input logic [2:0] f3,
                       input logic [31:0] wdata, input int unsigned waits,
                       input logic [31:0] rd, input logic slverr);
    rsp_t r; apb_t a; slv_t s;
    int unsigned lat, nbytes, off, sh, lo8, lo16, budget;
    logic ok;
    ok = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = 32'd1 << f3[1:0];
    off = addr % 4;
    if ((addr % nbytes) != 0) ok = 1'b0;
    r.rdata = 32'h0; r.err = 1'b1; lat = 1;
    a = '{32'h0, 1'b0, 4'h0, 32'h0};
    s = '{waits, rd, slverr};
    if (ok) begin
      a.addr  = addr;
      a.wr    = we;
      a.strb  = we ? 4'(((32'd1 << nbytes) - 32'd1) << off) : 4'h0;
      a.wdata = we ? (wdata << (8 * off)) : 32'h0;
      if (waits >= TO) begin
        lat = 2 + TO;
      end else begin
        lat = 3 + waits;
        r.err = slverr;
        if (!we && !slverr) begin
          sh = rd >> (8 * off);
          lo8 = sh % 256;
          lo16 = sh % 65536;
          case (f3)
            3'd0: r.rdata = (lo8 >= 128) ? 32'(lo8) - 32'd256 : 32'(lo8);
            3'd1: r.rdata = (lo16 >= 32768) ? 32'(lo16) - 32'd65536 : 32'(lo16);
            3'd4: r.rdata = 32'(lo8);
            3'd5: r.rdata = 32'(lo16);
            default: r.rdata = rd;
          endcase
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_funct3 = f3; req_wdata = wdata;
    budget = 0;
    while (!req_ready) begin
      budget++;
      if (budget > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL handshake: req_ready never rose, got 0 expected 1");
        finish_run();
      end
      @(negedge clk);
    end
    r.cyc = cyc + lat;
    rsp_q.push_back(r);
    if (ok) begin
      apb_q.push_back(a);
      slv_q.push_back(s);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned b;
    b = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0) && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("drain_left", 32'(rsp_q.size() + apb_q.size()), 32'd0);
  endtask

  // Response monitor
  rsp_t e;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0 at t=%0t", $time);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // APB bus monitor
  apb_t cur;
  logic have = 1'b0;
  always @(negedge clk) begin
    if (psel && !penable) begin
      if (apb_q.size() == 0) begin
        n_cmp++; n_bad++; have = 1'b0;
        $display("FAIL unexpected_setup: got psel 1 expected 0 at t=%0t", $time);
      end else begin
        cur = apb_q.pop_front(); have = 1'b1;
        chk("setup_paddr", paddr, cur.addr);
        chk("setup_pwrite", 32'(pwrite), 32'(cur.wr));
        chk("setup_pstrb", 32'(pstrb), 32'(cur.strb));
        chk("setup_pwdata", pwdata, cur.wdata);
      end
    end else if (psel && penable) begin
      if (have) begin
        chk("access_paddr", paddr, cur.addr);
        chk("access_pwrite", 32'(pwrite), 32'(cur.wr));
        chk("access_pstrb", 32'(pstrb), 32'(cur.strb));
        chk("access_pwdata", pwdata, cur.wdata);
      end
    end else begin
      chk("idle_bus", {paddr[31:1], |{paddr[0], pwdata, pstrb, penable}}, 32'h0);
    end
  end

  // Responder: pready after the scheduled number of waits; garbage data otherwise
  slv_t cs = '{0, 32'h0, 1'b0};
  int unsigned acnt = 0;
  always @(negedge clk) begin
    if (psel && penable) begin
      if (acnt == 0) begin
        if (slv_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_access: got penable 1 expected 0 at t=%0t", $time);
          cs = '{0, 32'h0, 1'b0};
        end else begin
          cs = slv_q.pop_front();
        end
      end
      acnt++;
      if (acnt - 1 == cs.waits) begin
        pready = 1'b1; prdata = cs.prdata; pslverr = cs.slverr;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
    end else begin
      acnt = 0; pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    end
  end

  logic [2:0]  f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  rf3;
  logic        rwe;
  logic [31:0] raddr;
  int unsigned rw, sel, b;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", {rsp_rdata[31:1], rsp_rdata[0] | rsp_valid | rsp_err}, 32'd0);
    chk("rst_apb", {paddr[31:1], |{paddr[0], pwdata, pstrb, psel, penable, pwrite}}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    issue(32'h100, 1'b0, 3'd2, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    issue(32'h103, 1'b1, 3'd0, 32'h000000A5, 0, 32'h0, 1'b0);
    issue(32'h102, 1'b0, 3'd0, 32'h0, 0, 32'h00800000, 1'b0);
    issue(32'h102, 1'b0, 3'd4, 32'h0, 1, 32'h00800000, 1'b0);
    issue(32'h101, 1'b0, 3'd1, 32'h0, 0, 32'h0, 1'b0);
    issue(32'h100, 1'b0, 3'd3, 32'h0, 0, 32'h0, 1'b0);
    issue(32'h100, 1'b1, 3'd4, 32'h12345678, 0, 32'h0, 1'b0);
    issue(32'h104, 1'b0, 3'd2, 32'h0, 40, 32'h0, 1'b0);
    issue(32'h108, 1'b0, 3'd2, 32'h0, 3, 32'hCAFEF00D, 1'b1);
    issue(32'h10C, 1'b0, 3'd2, 32'h0, TO - 1, 32'h55AA55AA, 1'b0);
    issue(32'h10E, 1'b1, 3'd1, 32'h0000BEEF, TO, 32'h0, 1'b0);
    issue(32'h112, 1'b0, 3'd5, 32'h0, 2, 32'h9ABC1234, 1'b0);
    drain();

    for (int i = 0; i < 80; i++) begin
      rwe = 1'($urandom);
      rf3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 4)];
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rf3[1:0] == 2'b01) raddr[0] = 1'b0;
        if (rf3[1:0] == 2'b10) raddr[1:0] = 2'b00;
      end
      sel = $urandom_range(0, 9);
      rw = (sel < 6) ? $urandom_range(0, 2) : (sel < 8) ? $urandom_range(3, 6) : $urandom_range(14, 18);
      issue(raddr, rwe, rf3, $urandom, rw, $urandom, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset while the transfer sits in ACCESS: bus drops at once, no response
    issue(32'h200, 1'b0, 3'd2, 32'h0, 10, 32'h1234, 1'b0);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(psel && penable) && b < 20);
    chk("reached_access", 32'(psel && penable), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_psel", 32'(psel), 32'd0);
    chk("async_penable", 32'(penable), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    rsp_q.delete(); apb_q.delete(); slv_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(32'h202, 1'b1, 3'd1, 32'h0000BEEF, 1, 32'h0, 1'b0);
    issue(32'h201, 1'b0, 3'd4, 32'h0, 0, 32'h00007F00, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    finish_run();
  end

endmodule
